// File: rtl/mix_i2s_tx_pkg.sv
// Shared widths, the serializer index width and the sample conversion used by mix_i2s_tx.
package mix_i2s_tx_pkg;

    localparam int IN_W_DEF       = 20;
    localparam int OUT_W_DEF      = 24;
    localparam int UNDERRUN_CNT_W = 16;
    localparam int CONV_MAX_W     = 64;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

    function automatic int k_width(input int out_w);
        return $clog2(2 * out_w);
    endfunction

    // Flip the offset-binary MSB, then left-justify into an out_w-bit slot.
    function automatic logic [CONV_MAX_W-1:0] offset_to_twos(
        input logic [CONV_MAX_W-1:0] s,
        input int                    in_w,
        input int                    out_w
    );
        logic [CONV_MAX_W-1:0] r;
        r = s ^ (CONV_MAX_W'(1) << (in_w - 1));
        return r << (out_w - in_w);
    endfunction

endpackage

// File: rtl/mix_i2s_fifo.sv
// Small synchronous sample FIFO; full/empty are registered from the fill count.
module mix_i2s_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + (AW + 1)'(1);
            2'b01:   count_next = count - (AW + 1)'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == DEPTH_C);
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mix_i2s_tx.sv
// I2S transmitter for the mixer output: FIFO, offset-to-two's-complement, same word on both slots.
// Optional MIX_I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit underrun_count output.
module mix_i2s_tx
    import mix_i2s_tx_pkg::*;
#(
    parameter int IN_W       = IN_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int BCLK_DIV   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IN_W-1:0] sample_in,
    input  logic            sample_valid,
    output logic            sample_ready,
    input  logic            mute,
    output logic            bclk,
    output logic            lrclk,
    output logic            sdata,
    output logic            underrun
`ifdef MIX_I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_W-1:0] underrun_count
`endif
);

    localparam int KW = k_width(OUT_W);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);
    localparam logic [KW-1:0] K_MID     = KW'(OUT_W);
    localparam logic [KW-1:0] K_LAST    = KW'(2 * OUT_W - 1);
    localparam logic [KW-1:0] K_CAPTURE = KW'(1);

    logic [DW-1:0]    div_cnt;
    logic [KW-1:0]    k;
    logic [KW-1:0]    k_next;
    logic [KW-1:0]    bit_idx;
    logic [OUT_W-1:0] word;
    logic [OUT_W-1:0] word_next;
    logic [IN_W-1:0]  fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             div_tc;
    logic             bclk_fall;
    logic             capture;
    logic             sdata_next;

    assign sample_ready = !fifo_full;
    assign push         = sample_valid && sample_ready;
    assign div_tc       = (div_cnt == DIV_LAST);
    assign bclk_fall    = div_tc && bclk;
    assign capture      = bclk_fall && (k_next == K_CAPTURE);
    assign pop          = capture && !fifo_empty;

    mix_i2s_fifo #(
        .WIDTH (IN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (sample_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Bit index: left slot carries word[OUT_W-k], right slot wraps so k=0 sends the LSB.
    always_comb begin
        k_next = (k == K_LAST) ? '0 : k + KW'(1);
        if (k_next == '0) begin
            bit_idx = '0;
        end else if (k_next <= K_MID) begin
            bit_idx = K_MID - k_next;
        end else begin
            bit_idx = K_LAST - k_next + KW'(1);
        end
    end

    // On an empty FIFO the previous word is repeated; mute wins over both cases.
    always_comb begin
        word_next = word;
        if (capture) begin
            if (mute) begin
                word_next = '0;
            end else if (!fifo_empty) begin
                word_next = OUT_W'(offset_to_twos(CONV_MAX_W'(fifo_dout), IN_W, OUT_W));
            end
        end
    end

    assign sdata_next = |(word_next & (OUT_W'(1) << bit_idx));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            bclk     <= 1'b0;
            k        <= '0;
            lrclk    <= 1'b0;
            sdata    <= 1'b0;
            word     <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= capture && fifo_empty;
            div_cnt  <= div_tc ? '0 : div_cnt + DW'(1);
            if (div_tc) bclk <= ~bclk;
            if (bclk_fall) begin
                k     <= k_next;
                lrclk <= (k_next >= K_MID) ? SLOT_RIGHT : SLOT_LEFT;
                sdata <= sdata_next;
            end
            word <= word_next;
        end
    end

`ifdef MIX_I2S_TX_UNDERRUN_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_count <= '0;
        end else if (underrun && (underrun_count != '1)) begin
            underrun_count <= underrun_count + UNDERRUN_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mix_i2s_tx.sv
// Directed bench for mix_i2s_tx: decodes I2S frames like a DAC and compares against hand-computed words.
module tb_mix_i2s_tx;

    typedef struct {
        logic [19:0] s0;
        logic [19:0] s1;
        int          npush;
        logic        mute;
        logic [23:0] exp_word;
        int          exp_und;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        mute;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;
`ifdef MIX_I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic        prev_bclk = 1'b0;
    logic        prev_lr   = 1'b0;
    logic        prev_und  = 1'b0;
    logic [23:0] rx_shift  = '0;
    logic [23:0] rx_left   = '0;
    logic [23:0] rx_right  = '0;
    int          frame_cnt  = 0;
    int          und_pulses = 0;
    int          und_long   = 0;

    mix_i2s_tx #(
        .IN_W       (20),
        .OUT_W      (24),
        .BCLK_DIV   (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .mute         (mute),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun     (underrun)
`ifdef MIX_I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    always #5 clk = ~clk;

    // DAC-side receiver: shift on bclk rise; an lrclk change marks the LSB of the finished slot.
    always @(negedge clk) begin
        if (reset) begin
            prev_bclk = 1'b0;
            prev_lr   = 1'b0;
            prev_und  = 1'b0;
            rx_shift  = '0;
        end else begin
            if (bclk && !prev_bclk) begin
                rx_shift = {rx_shift[22:0], sdata};
                if (lrclk != prev_lr) begin
                    if (lrclk) begin
                        rx_left = rx_shift;
                    end else begin
                        rx_right  = rx_shift;
                        frame_cnt = frame_cnt + 1;
                    end
                end
                prev_lr = lrclk;
            end
            prev_bclk = bclk;
            if (underrun) begin
                if (prev_und) und_long = und_long + 1;
                else          und_pulses = und_pulses + 1;
            end
            prev_und = underrun;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        mute = v.mute;
        if (v.npush >= 1) begin
            sample_in    = v.s0;
            sample_valid = 1'b1;
            step();
        end
        if (v.npush >= 2) begin
            sample_in = v.s1;
            step();
        end
        sample_valid = 1'b0;
    endtask

    task automatic waitFrame(input string name);
        int target;
        int n;
        target = frame_cnt + 1;
        n = 0;
        while (frame_cnt < target && n < 400) begin
            step();
            n++;
        end
        if (frame_cnt < target) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: no frame seen within 400 clks, expected one", name);
        end
    endtask

    task automatic waitLrRise(input string name);
        logic prev;
        int   n;
        prev = lrclk;
        n = 0;
        while (n < 400) begin
            step();
            n++;
            if (!prev && lrclk) break;
            prev = lrclk;
        end
        if (n >= 400) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: no lrclk rise within 400 clks, expected one", name);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t        vecs[11];
        logic [19:0] b_samples[5];
        logic [23:0] b_words[5];
        int          pushed;
        int          held;
        int          base;
        int          falls;
        logic        rdy;
        logic        prev;

        vecs[0]  = '{20'h00000, 20'h0, 1, 1'b0, 24'h800000, 0};
        vecs[1]  = '{20'hFFFFF, 20'h0, 1, 1'b0, 24'h7FFFF0, 0};
        vecs[2]  = '{20'h80000, 20'h0, 1, 1'b0, 24'h000000, 0};
        vecs[3]  = '{20'h00000, 20'h0, 0, 1'b0, 24'h000000, 1};
        vecs[4]  = '{20'h12345, 20'h0, 1, 1'b0, 24'h923450, 0};
        vecs[5]  = '{20'h00000, 20'h0, 0, 1'b0, 24'h923450, 1};
        vecs[6]  = '{20'hFFFFF, 20'h0ABCD, 2, 1'b1, 24'h000000, 0};
        vecs[7]  = '{20'h00000, 20'h0, 0, 1'b0, 24'h8ABCD0, 0};
        vecs[8]  = '{20'h00000, 20'h0, 0, 1'b0, 24'h8ABCD0, 1};
        vecs[9]  = '{20'h7FFFF, 20'h0, 1, 1'b0, 24'hFFFFF0, 0};
        vecs[10] = '{20'h00001, 20'h0, 1, 1'b0, 24'h800010, 0};

        b_samples = '{20'h00F0F, 20'hABCDE, 20'h55555, 20'hC0000, 20'h3FFFF};
        b_words   = '{24'h80F0F0, 24'h2BCDE0, 24'hD55550, 24'h400000, 24'hBFFFF0};

        reset        = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        mute         = 1'b0;

        // Reset values and the first bclk/lrclk edges.
        repeat (3) step();
        checkOutput("rst_bclk", bclk, 0);
        checkOutput("rst_lrclk", lrclk, 0);
        checkOutput("rst_sdata", sdata, 0);
        checkOutput("rst_underrun", underrun, 0);
        checkOutput("rst_ready", sample_ready, 1);
        reset = 1'b0;
        step();
        checkOutput("bclk_low_clk1", bclk, 0);
        step();
        checkOutput("bclk_rise_clk2", bclk, 1);
        repeat (93) step();
        checkOutput("lrclk_low_clk95", lrclk, 0);
        step();
        checkOutput("lrclk_rise_clk96", lrclk, 1);

        // Frame-by-frame vector table.
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            und_pulses = 0;
            applyStimulus(vecs[i]);
            waitFrame($sformatf("vec%0d_frame", i));
            checkOutput($sformatf("vec%0d_left", i), rx_left, vecs[i].exp_word);
            checkOutput($sformatf("vec%0d_right", i), rx_right, vecs[i].exp_word);
            checkOutput($sformatf("vec%0d_underrun", i), und_pulses, vecs[i].exp_und);
        end
        mute = 1'b0;

        // Five back-to-back pushes mid-frame: the fifth waits for the capture pop.
        waitLrRise("burst_lr");
        und_pulses   = 0;
        base         = frame_cnt;
        pushed       = 0;
        held         = 0;
        sample_valid = 1'b1;
        sample_in    = b_samples[0];
        for (int n = 0; n < 400 && pushed < 5; n++) begin
            rdy = sample_ready;
            step();
            if (rdy) begin
                pushed++;
                if (pushed == 4) checkOutput("ready_low_after_4", sample_ready, 0);
                if (pushed < 5) sample_in = b_samples[pushed];
            end else begin
                held++;
            end
        end
        sample_valid = 1'b0;
        checkOutput("burst_pushes", pushed, 5);
        checkOutput("fifth_held_off", held > 0, 1);
        checkOutput("fifth_after_capture", frame_cnt - base, 1);
        for (int j = 0; j < 5; j++) begin
            waitFrame($sformatf("burst%0d_frame", j));
            checkOutput($sformatf("burst%0d_left", j), rx_left, b_words[j]);
            checkOutput($sformatf("burst%0d_right", j), rx_right, b_words[j]);
        end
        checkOutput("burst_underrun", und_pulses, 0);

        // Reset at k=30 with bclk high and two samples queued.
        waitLrRise("midrst_lr");
        sample_valid = 1'b1;
        sample_in    = 20'h11111;
        step();
        sample_in = 20'h22222;
        step();
        sample_valid = 1'b0;
        prev  = bclk;
        falls = 0;
        for (int n = 0; n < 200 && falls < 6; n++) begin
            step();
            if (prev && !bclk) falls++;
            prev = bclk;
        end
        checkOutput("midrst_falls", falls, 6);
        for (int n = 0; n < 10 && !bclk; n++) step();
        reset = 1'b1;
        #1;
        checkOutput("midrst_bclk", bclk, 0);
        checkOutput("midrst_lrclk", lrclk, 0);
        checkOutput("midrst_sdata", sdata, 0);
        checkOutput("midrst_underrun", underrun, 0);
        checkOutput("midrst_ready", sample_ready, 1);
        step();
        step();
        reset      = 1'b0;
        und_pulses = 0;
        step();
        checkOutput("midrst_bclk_clk1", bclk, 0);
        step();
        checkOutput("midrst_bclk_clk2", bclk, 1);
        for (int f = 0; f < 3; f++) begin
            waitFrame($sformatf("empty%0d_frame", f));
            checkOutput($sformatf("empty%0d_left", f), rx_left, 0);
            checkOutput($sformatf("empty%0d_right", f), rx_right, 0);
            checkOutput($sformatf("empty%0d_underrun", f), und_pulses, 1);
            und_pulses = 0;
        end
`ifdef MIX_I2S_TX_UNDERRUN_CNT_EN
        checkOutput("underrun_count", underrun_count, 3);
`endif
        checkOutput("underrun_width", und_long, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
